pipe_shifter: RTL and testbench

PIPE_SHIFTER -- requirements
Module: pipe_shifter

---
 rtl/shifter_pkg.sv | 24 ++
 rtl/shifter_stage.sv | 71 +++++++
 rtl/pipe_shifter.sv | 84 ++++++++
 tb/tb_pipe_shifter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared op encodings and op-legality helper for the pipelined shifter.
// Optional feature macro: PIPE_SHIFTER_ROTATE_EN (enables ROL/ROR).
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  // True when the op code is implemented by this build.
  function automatic logic op_legal(input shift_op_e op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: op_legal = 1'b1;
`ifdef PIPE_SHIFTER_ROTATE_EN
      OP_ROL, OP_ROR:         op_legal = 1'b1;
`endif
      default:                op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// One barrel-shifter pipeline stage: conditionally shifts by SHIFT when the
// matching amount bit is set, then registers the whole operation.
// Optional feature macro: PIPE_SHIFTER_ROTATE_EN (rotate datapath).
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned SHIFT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       advance,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  shift_op_e                  in_op,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic                       in_err,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH)-1:0]   out_amt,
  output shift_op_e                  out_op,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_err
);

  localparam int unsigned BIT = $clog2(SHIFT);

  logic [WIDTH-1:0] shifted;

  // Apply this stage's power-of-two shift when its amount bit is set.
  // Illegal ops arrive with zeroed data, so passing through keeps them zero.
  always_comb begin
    shifted = in_data;
    if (in_amt[BIT]) begin
      case (in_op)
        OP_SLL:  shifted = in_data << SHIFT;
        OP_SRL:  shifted = in_data >> SHIFT;
        OP_SRA:  shifted = WIDTH'($signed(in_data) >>> SHIFT);
`ifdef PIPE_SHIFTER_ROTATE_EN
        OP_ROL:  shifted = {in_data[WIDTH-SHIFT-1:0], in_data[WIDTH-1:WIDTH-SHIFT]};
        OP_ROR:  shifted = {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
`endif
        default: shifted = in_data;
      endcase
    end
  end

  // Stage register: moves only on advance; payload captured for valid ops only.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_op    <= OP_SLL;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= shifted;
        out_amt  <= in_amt;
        out_op   <= in_op;
        out_tag  <= in_tag;
        out_err  <= in_err;
      end
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined shifter: LOG2W registered stages, stage k shifts by 2^k.
// Whole pipeline advances in lockstep when the output is empty or consumed.
// Optional feature macro: PIPE_SHIFTER_ROTATE_EN (ROL/ROR legal when defined).
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic             advance;
  shift_op_e        in_op_e;
  logic             in_legal;

  logic             s_valid [LOG2W+1];
  logic [WIDTH-1:0] s_data  [LOG2W+1];
  logic [LOG2W-1:0] s_amt   [LOG2W+1];
  shift_op_e        s_op    [LOG2W+1];
  logic [TAG_W-1:0] s_tag   [LOG2W+1];
  logic             s_err   [LOG2W+1];

  assign in_op_e  = shift_op_e'(in_op);
  assign in_legal = op_legal(in_op_e);
  assign advance  = !s_valid[LOG2W] || out_ready;
  assign in_ready = advance;

  // Illegal ops enter with zero data and the error flag; every stage then
  // passes them through unchanged, so latency matches legal ops.
  assign s_valid[0] = in_valid;
  assign s_data[0]  = in_legal ? in_data : '0;
  assign s_amt[0]   = in_amt;
  assign s_op[0]    = in_op_e;
  assign s_tag[0]   = in_tag;
  assign s_err[0]   = !in_legal;

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    shifter_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .SHIFT (1 << k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .in_valid  (s_valid[k]),
      .in_data   (s_data[k]),
      .in_amt    (s_amt[k]),
      .in_op     (s_op[k]),
      .in_tag    (s_tag[k]),
      .in_err    (s_err[k]),
      .out_valid (s_valid[k+1]),
      .out_data  (s_data[k+1]),
      .out_amt   (s_amt[k+1]),
      .out_op    (s_op[k+1]),
      .out_tag   (s_tag[k+1]),
      .out_err   (s_err[k+1])
    );
  end

  assign out_valid = s_valid[LOG2W];
  assign out_data  = s_data[LOG2W];
  assign out_tag   = s_tag[LOG2W];
  assign out_err   = s_err[LOG2W];

  // Amount and op are spent once the last stage has shifted.
  logic unused_last;
  assign unused_last = ^{s_amt[LOG2W], s_op[LOG2W]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter (WIDTH=32, TAG_W=4).
module tb_pipe_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];

  pipe_shifter #(.WIDTH(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Direct reference model of one operation.
  function automatic exp_t model(input logic [31:0] d, input logic [4:0] a,
                                 input logic [2:0] op, input logic [3:0] t);
    exp_t e;
    e.tag = t;
    e.err = 1'b0;
    e.cyc = 0;
    case (op)
      3'b000:  e.data = d << a;
      3'b001:  e.data = d >> a;
      3'b010:  e.data = $signed(d) >>> a;
`ifdef PIPE_SHIFTER_ROTATE_EN
      3'b011:  e.data = (d << a) | (d >> (32 - int'(a)));
      3'b100:  e.data = (d >> a) | (d << (32 - int'(a)));
`endif
      default: begin e.data = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge; push the expectation
  // when the handshake will occur at the coming rising edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a,
                       input logic [2:0] op, input logic [3:0] t, input logic ordy,
                       output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_op     = op;
    in_tag    = t;
    out_ready = ordy;
    cyc++;
    #1;
    acc = v && in_ready;
    if (acc) begin
      e = model(d, a, op, t);
      e.cyc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0;
    in_tag = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: valid=%b data=%h tag=%h err=%b want 0 0 0 0",
               out_valid, out_data, out_tag, out_err);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_sra();
    logic acc;
    exp_t e;
    int got = 0;
    logic [31:0] want_d [2];
    logic [3:0]  want_t [2];
    want_d[0] = 32'hF800_0000; want_t[0] = 4'd3;
    want_d[1] = 32'h8000_0001; want_t[1] = 4'd5;
    drive(1'b1, 32'h8000_0000, 5'd4, 3'b010, 4'd3, 1'b1, acc);
    drive(1'b1, 32'h8000_0001, 5'd0, 3'b010, 4'd5, 1'b1, acc);
    for (int i = 0; i < 20 && got < 2; i++) begin
      drive(1'b0, $urandom, 5'($urandom), 3'($urandom), 4'($urandom), 1'b1, acc);
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sra_extra: unexpected result data=%h", out_data);
        end else begin
          e = q.pop_front();
          if (out_data !== want_d[got] || out_tag !== want_t[got] || out_err !== 1'b0 ||
              (cyc - e.cyc) != 5) begin
            bad++;
            $display("FAIL sra_%0d: data=%h tag=%0d err=%b lat=%0d want %h %0d 0 5",
                     got, out_data, out_tag, out_err, cyc - e.cyc, want_d[got], want_t[got]);
          end
        end
        got++;
      end
    end
    total++;
    if (got != 2) begin
      bad++;
      $display("FAIL sra_timeout: results=%0d want 2", got);
    end
  endtask

  task automatic test_rotate();
    logic acc;
    int got = 0;
    logic [31:0] want_d;
    logic        want_e;
`ifdef PIPE_SHIFTER_ROTATE_EN
    want_d = 32'h0000_0003; want_e = 1'b0;
`else
    want_d = 32'h0000_0000; want_e = 1'b1;
`endif
    drive(1'b1, 32'h8000_0001, 5'd1, 3'b011, 4'd6, 1'b1, acc);
    for (int i = 0; i < 20 && got < 1; i++) begin
      drive(1'b0, $urandom, 5'($urandom), 3'($urandom), 4'($urandom), 1'b1, acc);
      if (out_valid && out_ready) begin
        void'(q.pop_front());
        total++;
        if (out_data !== want_d || out_err !== want_e || out_tag !== 4'd6) begin
          bad++;
          $display("FAIL rol: data=%h err=%b tag=%0d want %h %b 6",
                   out_data, out_err, out_tag, want_d, want_e);
        end
        got++;
      end
    end
    total++;
    if (got != 1) begin
      bad++;
      $display("FAIL rol_timeout: results=%0d want 1", got);
    end
  endtask

  task automatic test_illegal();
    logic acc;
    int got = 0;
    logic [3:0] want_t [2];
    want_t[0] = 4'd9; want_t[1] = 4'd12;
    drive(1'b1, 32'hDEAD_BEEF, 5'd7, 3'b111, 4'd9, 1'b1, acc);
    drive(1'b1, 32'hFFFF_FFFF, 5'd0, 3'b101, 4'd12, 1'b1, acc);
    for (int i = 0; i < 20 && got < 2; i++) begin
      drive(1'b0, $urandom, 5'($urandom), 3'($urandom), 4'($urandom), 1'b1, acc);
      if (out_valid && out_ready) begin
        void'(q.pop_front());
        total++;
        if (out_data !== 32'h0 || out_err !== 1'b1 || out_tag !== want_t[got]) begin
          bad++;
          $display("FAIL illegal_%0d: data=%h err=%b tag=%0d want 0 1 %0d",
                   got, out_data, out_err, out_tag, want_t[got]);
        end
        got++;
      end
    end
    total++;
    if (got != 2) begin
      bad++;
      $display("FAIL illegal_timeout: results=%0d want 2", got);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic ordy;
    int n = 0;
    int got = 0;
    for (int i = 0; i < 60 && got < 8; i++) begin
      ordy = !(i >= 6 && i <= 9);
      drive(n < 8, 32'h1, 5'(n), 3'b000, 4'(n), ordy, acc);
      if (acc) n++;
      if (out_valid && !out_ready) begin
        total++;
        if (out_data !== (32'h1 << got) || out_tag !== 4'(got) || in_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b_hold: data=%h tag=%0d in_ready=%b want %h %0d 0",
                   out_data, out_tag, in_ready, 32'h1 << got, got);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: unexpected result data=%h", out_data);
        end else begin
          void'(q.pop_front());
          if (out_data !== (32'h1 << got) || out_tag !== 4'(got) || out_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_%0d: data=%h tag=%0d err=%b want %h %0d 0",
                     got, out_data, out_tag, out_err, 32'h1 << got, got);
          end
        end
        got++;
      end
    end
    total++;
    if (got != 8 || q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: results=%0d pending=%0d want 8 0", got, q.size());
    end
  endtask

  task automatic test_mid_reset();
    logic acc;
    drive(1'b1, 32'h0000_00F0, 5'd2, 3'b000, 4'd1, 1'b1, acc);
    drive(1'b1, 32'h0000_00F0, 5'd3, 3'b001, 4'd2, 1'b1, acc);
    drive(1'b1, 32'h8000_00F0, 5'd4, 3'b010, 4'd3, 1'b1, acc);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state: valid=%b data=%h tag=%h err=%b want 0 0 0 0",
               out_valid, out_data, out_tag, out_err);
    end
    rst = 1'b0;
    q.delete();
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_ready: in_ready=%b want 1", in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, $urandom, 5'($urandom), 3'($urandom), 4'($urandom), 1'b1, acc);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_stale: out_valid=%b data=%h want 0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_random();
    logic acc;
    exp_t e;
    int got = 0;
    for (int i = 0; i < 200 && (i < 80 || q.size() != 0); i++) begin
      if (i < 80)
        drive(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom), 3'($urandom_range(0, 7)),
              4'($urandom), 1'($urandom_range(0, 2) != 0), acc);
      else
        drive(1'b0, $urandom, 5'($urandom), 3'($urandom), 4'($urandom), 1'b1, acc);
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra: unexpected result data=%h", out_data);
        end else begin
          e = q.pop_front();
          if (out_data !== e.data || out_tag !== e.tag || out_err !== e.err) begin
            bad++;
            $display("FAIL rand_%0d: data=%h tag=%0d err=%b want %h %0d %b",
                     got, out_data, out_tag, out_err, e.data, e.tag, e.err);
          end
        end
        got++;
      end
    end
    total++;
    if (q.size() != 0 || got == 0) begin
      bad++;
      $display("FAIL rand_drain: pending=%0d results=%0d", q.size(), got);
    end
  endtask

  initial begin
    test_reset();
    test_sra();
    test_rotate();
    test_illegal();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
